// File: rtl/ctrl_pkg.sv
// Shared definitions for the y/s datapath controller: state encoding and mode helpers.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int MODE_OFF = 0;

    // True when the low 'width' bits of mode are all ones (continuous mode).
    function automatic logic is_cont(input logic [31:0] mode, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (mode & mask) == mask;
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the accumulate phase; clear has priority over increment.
module iter_counter #(
    parameter int CNT_W = 3,
    parameter int ITERS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/control_path_param.sv
// Moore control FSM sequencing one y/s run: INIT (load y, clear s), ITERS accumulate
// steps, then a one-cycle done; all-ones mode restarts automatically.
module control_path_param
    import ctrl_pkg::*;
#(
    parameter int MODE_W = 2,
    parameter int SEL_W  = 2,
    parameter int ITERS  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] on,
    input  logic              start,
    input  logic              stop,
    output logic [MODE_W-1:0] regime,
    output logic              active,
    output logic              done,
    output logic [SEL_W-1:0]  y_select_next,
    output logic [CNT_W-1:0]  s_step,
    output logic              y_en,
    output logic              s_en,
    output logic              y_store_x,
    output logic              s_add,
    output logic              s_zero
);

    state_e            state_q, state_d;
    logic [MODE_W-1:0] regime_q, regime_d;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic              cnt_clr;
    logic              cnt_inc;

    // Counter runs only in ITER; any other state parks it at zero.
    assign cnt_inc = (state_q == ST_ITER);
    assign cnt_clr = (state_q != ST_ITER) || cnt_last;

    iter_counter #(
        .CNT_W (CNT_W),
        .ITERS (ITERS)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        regime_d = regime_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop && (on != MODE_W'(MODE_OFF))) begin
                    regime_d = on;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: state_d = stop ? ST_IDLE : ST_ITER;
            ST_ITER: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!stop && is_cont(32'(regime_q), MODE_W)) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            regime_q <= '0;
        end else begin
            state_q  <= state_d;
            regime_q <= regime_d;
        end
    end

    always_comb begin
        active        = 1'b0;
        done          = 1'b0;
        y_select_next = '0;
        s_step        = '0;
        y_en          = 1'b0;
        s_en          = 1'b0;
        y_store_x     = 1'b0;
        s_add         = 1'b0;
        s_zero        = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                active    = 1'b1;
                y_en      = 1'b1;
                s_en      = 1'b1;
                y_store_x = 1'b1;
                s_zero    = 1'b1;
            end
            ST_ITER: begin
                active        = 1'b1;
                y_en          = 1'b1;
                s_en          = 1'b1;
                s_add         = 1'b1;
                y_select_next = SEL_W'(regime_q);
                s_step        = cnt;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign regime = regime_q;

endmodule

// File: tb/tb_control_path_param.sv
// Randomised and directed bench for control_path_param against a run-position model.
module tb_control_path_param;

    localparam int ITERS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] on = 2'b00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] regime;
    logic       active, done, y_en, s_en, y_store_x, s_add, s_zero;
    logic [1:0] y_select_next;
    logic [2:0] s_step;

    logic [1:0] on1 = 2'b00;
    logic       start1 = 1'b0;
    logic       stop1 = 1'b0;
    logic [1:0] regime1;
    logic       active1, done1, y_en1, s_en1, y_store_x1, s_add1, s_zero1;
    logic [1:0] y_select_next1;
    logic [0:0] s_step1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_path_param #(.MODE_W(2), .SEL_W(2), .ITERS(ITERS), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .on(on), .start(start), .stop(stop),
        .regime(regime), .active(active), .done(done), .y_select_next(y_select_next),
        .s_step(s_step), .y_en(y_en), .s_en(s_en), .y_store_x(y_store_x),
        .s_add(s_add), .s_zero(s_zero)
    );

    control_path_param #(.MODE_W(2), .SEL_W(2), .ITERS(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .on(on1), .start(start1), .stop(stop1),
        .regime(regime1), .active(active1), .done(done1), .y_select_next(y_select_next1),
        .s_step(s_step1), .y_en(y_en1), .s_en(s_en1), .y_store_x(y_store_x1),
        .s_add(s_add1), .s_zero(s_zero1)
    );

    // Model: a run is a sequence of positions 0 (load), 1..ITERS (accumulate), ITERS+1 (done).
    logic       m_busy;
    int         m_pos;
    logic [1:0] m_reg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
            m_reg  <= 2'b00;
        end else if (!m_busy) begin
            if (start && !stop && on != 2'b00) begin
                m_busy <= 1'b1;
                m_pos  <= 0;
                m_reg  <= on;
            end
        end else if (stop) begin
            m_busy <= 1'b0;
        end else if (m_pos == ITERS + 1) begin
            if (m_reg == 2'b11) m_pos <= 0;
            else m_busy <= 1'b0;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    function automatic logic [13:0] model_vec();
        logic       act, dn, ini, it;
        logic [2:0] step;
        logic [1:0] sel;
        act  = m_busy && (m_pos <= ITERS);
        it   = m_busy && (m_pos >= 1) && (m_pos <= ITERS);
        ini  = m_busy && (m_pos == 0);
        dn   = m_busy && (m_pos == ITERS + 1);
        step = it ? 3'(m_pos - 1) : 3'd0;
        sel  = it ? m_reg : 2'b00;
        return {m_reg, act, dn, sel, step, act, act, ini, it, ini};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {regime, active, done, y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero};
    endfunction

    function automatic logic [11:0] dut1_vec();
        return {regime1, active1, done1, y_select_next1, s_step1, y_en1, s_en1, y_store_x1, s_add1, s_zero1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dut_vec() !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 14'd0);
        end
        vectors++;
        if (dut1_vec() !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_iters1 got=%h exp=%h", dut1_vec(), 12'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_idle got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_single();
        on = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL single_vec cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            vectors++;
            if (done !== (i == 6)) begin
                miscompares++;
                $display("FAIL single_done cyc=%0d got=%b exp=%b", i, done, (i == 6));
            end
            if (i == 1) begin
                vectors++;
                if ({y_store_x, s_zero, y_en, s_en, s_add} !== 5'b11110) begin
                    miscompares++;
                    $display("FAIL single_init got=%b exp=11110", {y_store_x, s_zero, y_en, s_en, s_add});
                end
            end
            if (i >= 2 && i <= 5) begin
                vectors++;
                if ({s_step, s_add, y_select_next} !== {3'(i - 2), 1'b1, 2'b01}) begin
                    miscompares++;
                    $display("FAIL single_iter cyc=%0d got=%h exp=%h", i, {s_step, s_add, y_select_next},
                             {3'(i - 2), 1'b1, 2'b01});
                end
            end
            if (i < 7) tick();
        end
        vectors++;
        if ({regime, active} !== 3'b010) begin
            miscompares++;
            $display("FAIL single_idle got=%b exp=010", {regime, active});
        end
    endtask

    task automatic test_continuous();
        on = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL cont_vec cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            vectors++;
            if (done !== (i == 6 || i == 12)) begin
                miscompares++;
                $display("FAIL cont_done cyc=%0d got=%b exp=%b", i, done, (i == 6 || i == 12));
            end
            if (i == 7 || i == 13) begin
                vectors++;
                if (y_store_x !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cont_restart cyc=%0d got=%b exp=1", i, y_store_x);
                end
            end
            if (i >= 16) begin
                vectors++;
                if (active !== 1'b0) begin
                    miscompares++;
                    $display("FAIL cont_stopped cyc=%0d active got=%b exp=0", i, active);
                end
            end
            if (i == 15) stop = 1'b1;
            if (i == 16) stop = 1'b0;
            tick();
        end
    endtask

    task automatic test_ignored();
        on = 2'b00; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== {2'b11, 12'd0}) begin
                miscompares++;
                $display("FAIL off_start got=%h exp=%h", dut_vec(), {2'b11, 12'd0});
            end
        end
        on = 2'b01; stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== {2'b11, 12'd0}) begin
                miscompares++;
                $display("FAIL start_stop got=%h exp=%h", dut_vec(), {2'b11, 12'd0});
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_midrun();
        on = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL midrun_vec cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            vectors++;
            if (done !== (i == 6)) begin
                miscompares++;
                $display("FAIL midrun_done cyc=%0d got=%b exp=%b", i, done, (i == 6));
            end
            if (i == 5) begin
                vectors++;
                if (y_select_next !== 2'b01) begin
                    miscompares++;
                    $display("FAIL midrun_sel got=%b exp=01", y_select_next);
                end
            end
            if (i == 4) begin
                on = 2'b10; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        on = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (dut_vec() !== 14'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(), 14'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec() || done !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        test_single();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            on    = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random_vec cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        start = 1'b0; stop = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_iters1();
        logic [11:0] exp;
        on1 = 2'b10; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            case (i)
                1:       exp = {2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
                2:       exp = {2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
                3:       exp = {2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                default: exp = {2'b10, 10'd0};
            endcase
            vectors++;
            if (dut1_vec() !== exp) begin
                miscompares++;
                $display("FAIL iters1 cyc=%0d got=%h exp=%h", i, dut1_vec(), exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_ignored();
        test_midrun();
        test_async_reset();
        test_random();
        test_iters1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
